eth_frame_loop_tx: RTL

- Transmit-side partner of the frame loop receiver. Reads one checksum descriptor from the csum FIFO, then streams the matching frame from the frame FIFO to the MAC TX AXI-Stream.
- When the descriptor requests it, overwrites the 16-bit transport checksum in flight, at the byte offset the descriptor carries.
- Keeps per-block frame counters for the statistics registers.

---
 rtl/eth_frame_loop_tx_if.sv | 35 +++
 rtl/eth_frame_loop_tx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/eth_frame_loop_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_frame_loop_tx_if
// Description : Byte/word AXI-Stream bundle used by the frame loop TX block
//               for the descriptor input, frame input and MAC output.
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_frame_loop_tx_if #(
    parameter int C_DATA_WIDTH = 8
) ();
    logic [C_DATA_WIDTH-1:0] tdata;
    logic                    tuser;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    // Source side of the stream
    modport master (
        output tdata,
        output tuser,
        output tlast,
        output tvalid,
        input  tready
    );

    // Sink side of the stream
    modport slave (
        input  tdata,
        input  tuser,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/eth_frame_loop_tx.sv
`default_nettype none
// ============================================================================
// Module      : eth_frame_loop_tx
// Description : Transmit side of the frame loop. Takes one checksum
//               descriptor, then forwards the matching frame to the MAC,
//               optionally overwriting the 16-bit transport checksum in
//               flight. Counts forwarded and patched frames.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_frame_loop_tx #(
    parameter int C_COUNTER_WIDTH = 32
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    eth_frame_loop_tx_if.slave              s_axis_csum,
    eth_frame_loop_tx_if.slave              s_axis_frame,
    eth_frame_loop_tx_if.master             m_axis,
    output logic [C_COUNTER_WIDTH-1:0]      count_frames,
    output logic [C_COUNTER_WIDTH-1:0]      count_patched
);

    localparam logic [C_COUNTER_WIDTH-1:0] C_CNT_ONE = {{(C_COUNTER_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_FORWARD = 1'b1
    } state_t;

    state_t      state;
    logic        csum_ready;   // descriptor accept, low for the first cycle out of reset
    logic [15:0] csum;         // replacement checksum
    logic [15:0] off;          // byte offset of the checksum high byte (always even)
    logic        patch;        // descriptor requests a checksum overwrite
    logic [15:0] idx;          // byte index within the current frame, saturating
    logic        hi_done;
    logic        lo_done;

    logic        fwd;
    logic [15:0] off_lo;
    logic        idx_sat;
    logic        hi_hit;
    logic        lo_hit;
    logic        beat;
    logic        desc_accept;

    assign fwd     = (state == ST_FORWARD);
    // off is even, so off+1 is just the LSB set; no carry can occur.
    assign off_lo  = {off[15:1], 1'b1};
    assign idx_sat = &idx;
    assign hi_hit  = patch && (idx == off);
    // Once idx has saturated it no longer identifies a unique byte, so the
    // low byte at 0xFFFF is treated as unreachable rather than patching every
    // byte past the saturation point.
    assign lo_hit  = patch && (idx == off_lo) && !idx_sat;
    assign beat    = fwd && s_axis_frame.tvalid && m_axis.tready;
    assign desc_accept = csum_ready && s_axis_csum.tvalid;

    // Zero-latency pass-through while forwarding; everything idles otherwise
    assign s_axis_csum.tready  = csum_ready;
    assign s_axis_frame.tready = fwd && m_axis.tready;
    assign m_axis.tvalid       = fwd && s_axis_frame.tvalid;
    assign m_axis.tuser        = fwd && s_axis_frame.tuser;
    assign m_axis.tlast        = fwd && s_axis_frame.tlast;

    // Output byte: replace the checksum bytes when the index matches
    always_comb begin
        m_axis.tdata = 8'h00;
        if (fwd) begin
            if (hi_hit) begin
                m_axis.tdata = csum[15:8];
            end else if (lo_hit) begin
                m_axis.tdata = csum[7:0];
            end else begin
                m_axis.tdata = s_axis_frame.tdata;
            end
        end
    end

    // Control FSM: descriptor latch, byte indexing, patch tracking, counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            csum_ready    <= 1'b0;
            csum          <= 16'h0000;
            off           <= 16'h0000;
            patch         <= 1'b0;
            idx           <= 16'h0000;
            hi_done       <= 1'b0;
            lo_done       <= 1'b0;
            count_frames  <= '0;
            count_patched <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (desc_accept) begin
                        csum       <= s_axis_csum.tdata[31:16];
                        off        <= {s_axis_csum.tdata[15:1], 1'b0};
                        patch      <= s_axis_csum.tdata[0];
                        idx        <= 16'h0000;
                        hi_done    <= 1'b0;
                        lo_done    <= 1'b0;
                        csum_ready <= 1'b0;
                        state      <= ST_FORWARD;
                    end else begin
                        csum_ready <= 1'b1;
                    end
                end
                ST_FORWARD: begin
                    if (beat) begin
                        if (!idx_sat) begin
                            idx <= idx + 16'd1;
                        end
                        if (hi_hit) begin
                            hi_done <= 1'b1;
                        end
                        if (lo_hit) begin
                            lo_done <= 1'b1;
                        end
                        if (s_axis_frame.tlast) begin
                            count_frames <= count_frames + C_CNT_ONE;
                            if ((hi_done || hi_hit) && (lo_done || lo_hit)) begin
                                count_patched <= count_patched + C_CNT_ONE;
                            end
                            csum_ready <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    csum_ready <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
